// File: rtl/uart_pkg.sv
// Shared UART definitions: TX queue FSM states, default sizing and
// Peripheral status-register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } tx_q_state_t;

    localparam int          UART_TX_DEPTH       = 16;
    localparam logic [15:0] UART_LAUNCH_TIMEOUT = 16'd50000;

    localparam int UART_ST_FULL     = 0;
    localparam int UART_ST_EMPTY    = 1;
    localparam int UART_ST_OVERFLOW = 2;
    localparam int UART_ST_TIMEOUT  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wr_data;
    end

    assign rd_data = mem[rptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// TX byte queue feeding uart_sender through a tx_en/tx_status handshake,
// with launch timeout and sticky overflow/timeout flags.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int          DEPTH          = UART_TX_DEPTH,
    parameter int          AW             = 4,
    parameter logic [15:0] LAUNCH_TIMEOUT = UART_LAUNCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_status,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        timeout_err,
    input  logic        err_clr
);

    tx_q_state_t state;
    tx_q_state_t state_nx;
    logic [15:0] timer;
    logic [7:0]  head;
    logic        pop;
    logic        tmo;
    logic        ovf;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign ovf = wr_en && full && !pop;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && tx_status) begin
                    pop      = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_status) begin
                    state_nx = WAIT_DONE;
                end else if (timer == LAUNCH_TIMEOUT) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_status)
                    state_nx = GAP;
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx_en <= 1'b0;
        end else begin
            state <= state_nx;
            tx_en <= (state_nx == LAUNCH);
        end
    end

    // tx_data only changes on a pop, so it holds through the whole byte
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data <= 8'h00;
            timer   <= '0;
        end else if (pop) begin
            tx_data <= head;
            timer   <= '0;
        end else if (state == LAUNCH) begin
            timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ovf)
                overflow <= 1'b1;
            if (tmo)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit byte queue between the `Peripheral` UART TX register and `uart_sender`. CPU stores to the TX register no longer stall or drop while a byte is on the wire. Bytes are buffered in a small FIFO and launched to the sender one at a time through an explicit tx_en/tx_status handshake. Status outputs (`full`, `empty`, `count`, sticky errors) feed the Peripheral's UART status register.

## Interface
Parameters:
- `DEPTH`, 16: queue entries; power of two, 2..64.
- `AW`, 4: log2(DEPTH).
- `LAUNCH_TIMEOUT`, 16'd50000: clk cycles allowed for the sender to go busy after `tx_en` rises.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, same as the pipeline.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  one-cycle pulse; CPU store to the TX data register.
- `wr_data`  in  8  byte to queue.
- `tx_en`  out  1  launch request to `uart_sender`.
- `tx_data`  out  8  byte being launched; stable from `tx_en` rise until the byte is done.
- `tx_status`  in  1  from `uart_sender`: 1 = idle, 0 = busy shifting.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  AW+1  bytes queued. The byte in flight is excluded.
- `overflow`  out  1  sticky: a write was dropped.
- `timeout_err`  out  1  sticky: the sender never went busy.
- `err_clr`  in  1  one-cycle pulse; clears both sticky flags.

## Operation
- FIFO: circular buffer, AW-bit read/write pointers that wrap modulo DEPTH, plus an (AW+1)-bit count register.
- Push: `wr_en && (!full || pop)`. A write while `full` is accepted only if a pop happens in the same cycle. Otherwise the write is dropped and `overflow` sets.
- Pop: occurs only on the IDLE→LAUNCH transition. The head byte is registered into `tx_data`.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states:
  - IDLE: if `!empty && tx_status`, pop and go to LAUNCH.
  - LAUNCH: `tx_en`=1. If `tx_status`==0, go to WAIT_DONE. If the timer reaches LAUNCH_TIMEOUT, set `timeout_err`, drop the byte and go to IDLE.
  - WAIT_DONE: `tx_en`=0. When `tx_status`==1, go to GAP.
  - GAP: one cycle, `tx_en`=0, then go to IDLE. This guarantees the sender sees `tx_en` low between bytes.
- Timer: 16-bit. Cleared on entry to LAUNCH and increments each cycle in LAUNCH.
- `tx_en` is driven from a register decoded from the state, so it is glitch-free.
- `err_clr` has priority over a new error in the same cycle: the flag reads 0, and the error is lost.
- Byte order on `tx_data` is strictly FIFO order.

## Timing
- Reset values: state IDLE, pointers 0, `count`=0, `empty`=1, `full`=0, `tx_en`=0, `tx_data`=8'h00, `overflow`=0, `timeout_err`=0, timer 0. Reset mid-transfer abandons the in-flight byte and the queue contents.
- `count`, `empty` and `full` are registered and reflect a push/pop one cycle after the edge that performs it.
- Write at cycle N into an empty queue with the sender idle:
  - cycle N+1: `empty`=0.
  - cycle N+2: `tx_en`=1, `tx_data` valid.
- `tx_en` is held until `tx_status` is sampled 0; its width is not bounded by baud timing.
- Back-to-back bytes: the next `tx_en` rises no earlier than 2 cycles after `tx_status` returns to 1 (WAIT_DONE→GAP→IDLE→LAUNCH).
- Sender already busy (`tx_status`=0) while in IDLE: hold IDLE; no pop.
- `tx_status` is treated as synchronous to `clk`; the sender synchronises its own output.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_q_state_t` {IDLE, LAUNCH, WAIT_DONE, GAP}.
  - constant `UART_TX_DEPTH`=16.
  - constant `UART_LAUNCH_TIMEOUT`.
  - Peripheral status-bit positions for `full`, `empty`, `overflow` and `timeout_err`.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/count/full/empty). It is reusable for a later RX queue.
- The FSM, timer and sticky flags live in `uart_tx_queue`.

## Test plan
- Single byte: write 8'h5A to an idle queue with sender idle → `tx_en` high at N+2 with `tx_data`=8'h5A. Model drops `tx_status` 3 cycles later → `tx_en` low the next cycle; `empty`=1.
- Burst: 5 writes (8'h01..8'h05) on consecutive cycles; model holds busy 100 cycles per byte → bytes leave in order 01..05, each `tx_en` preceded by at least one low cycle; `count` peaks at 4.
- Overflow: sender held busy; 17 writes → `count`=16, `full`=1, `overflow`=1, and the 17th byte is never sent. Then `err_clr` → `overflow`=0.
- Full plus same-cycle pop: queue full, sender returns idle, write arrives on the pop cycle → write accepted, `count` stays 16, no overflow.
- Timeout: sender model never lowers `tx_status` → after 50000 cycles in LAUNCH, `timeout_err`=1, FSM returns to IDLE and launches the next queued byte.
- Reset mid-transfer: assert `reset` for 1 cycle during WAIT_DONE with 3 bytes queued → next cycle `tx_en`=0, `count`=0, `empty`=1, and no further launches.
